// File: rtl/consec_pulse_gen.sv
// Retriggerable run generator: b stays high for RUN_LEN cycles from the latest
// accepted trigger; counts runs started from idle and flags retriggers.
module consec_pulse_gen #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             a,
  output logic                             b,
  output logic                             busy,
  output logic [$clog2(RUN_LEN+1)-1:0]     rem,
  output logic [CNT_W-1:0]                 burst_cnt,
  output logic                             retrig
);

  localparam int REM_W = $clog2(RUN_LEN + 1);
  localparam logic [REM_W-1:0] RELOAD = REM_W'(RUN_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic              acc;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retrig_q, retrig_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign acc   = en && a;
  // The only state is the owed-cycle count; IDLE/RUN is just its zero test.
  assign state = (rem_q != '0) ? RUN : IDLE;

  always_comb begin
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    retrig_d = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          rem_d = RELOAD;
          cnt_d = sat_inc(cnt_q);
        end
      end
      RUN: begin
        retrig_d = acc;
        rem_d    = acc ? RELOAD : rem_q - REM_W'(1);
      end
      default: begin
        rem_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q    <= '0;
      cnt_q    <= '0;
      retrig_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      retrig_q <= retrig_d;
    end
  end

  // b follows the trigger combinationally so a run starts in the trigger cycle.
  assign b         = rst && (acc || (state == RUN));
  assign busy      = (state == RUN);
  assign rem       = rem_q;
  assign burst_cnt = cnt_q;
  assign retrig    = retrig_q;

endmodule

// File: tb/tb_consec_pulse_gen.sv
// Bench for consec_pulse_gen: directed run scenarios, random traffic, counter
// saturation, and a RUN_LEN=1 instance, all scored against a cycle model.
module tb_consec_pulse_gen;

  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst, en, a;

  logic       b, busy, retrig;
  logic [1:0] rem;
  logic [7:0] cnt;

  logic       b2, busy2, retrig2;
  logic [1:0] rem2;
  logic [1:0] cnt2;

  logic       b1, busy1, retrig1;
  logic [0:0] rem1;
  logic [7:0] cnt1;

  always #5 clk = ~clk;

  consec_pulse_gen #(.RUN_LEN(RL), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .busy(busy),
    .rem(rem), .burst_cnt(cnt), .retrig(retrig));

  consec_pulse_gen #(.RUN_LEN(RL), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b2), .busy(busy2),
    .rem(rem2), .burst_cnt(cnt2), .retrig(retrig2));

  consec_pulse_gen #(.RUN_LEN(1), .CNT_W(8)) u_one (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b1), .busy(busy1),
    .rem(rem1), .burst_cnt(cnt1), .retrig(retrig1));

  typedef struct {
    int rem;
    int cnt;
    int cnt2;
    int cnt1;
    int retrig;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  int m_rem = 0, m_cnt = 0, m_cnt2 = 0, m_cnt1 = 0, m_retrig = 0;
  int owe = 0;
  logic [31:0] bh, rh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive at negedge, check combinational b, push the registered
  // expectation, then pop and compare it after the rising edge.
  task automatic step(input logic r, input logic e, input logic aa, input int idx);
    int   acc;
    exp_t x;
    exp_t y;
    @(negedge clk);
    rst = r; en = e; a = aa;
    #1;
    chk("b", 32'(b), 32'(r && ((e && aa) || m_rem != 0)));
    chk("b_sat", 32'(b2), 32'(r && ((e && aa) || m_rem != 0)));
    chk("b_len1", 32'(b1), 32'(r && e && aa));
    if (r && owe > 0) chk("prop_run", 32'(b), 32'd1);
    if (idx >= 0 && idx < 32) begin
      bh[idx] = b;
      rh[idx] = retrig;
    end
    acc = (r && e && aa) ? 1 : 0;
    if (!r) begin
      m_rem = 0; m_cnt = 0; m_cnt2 = 0; m_cnt1 = 0; m_retrig = 0; owe = 0;
    end else begin
      m_retrig = (acc != 0 && m_rem != 0) ? 1 : 0;
      if (acc != 0 && m_rem == 0) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (acc != 0 && m_cnt1 < 255) m_cnt1++;
      if (acc != 0) m_rem = RL - 1;
      else if (m_rem > 0) m_rem--;
      owe = (acc != 0) ? RL - 1 : ((owe > 0) ? owe - 1 : 0);
    end
    x.rem = m_rem; x.cnt = m_cnt; x.cnt2 = m_cnt2; x.cnt1 = m_cnt1; x.retrig = m_retrig;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    y = sb_q.pop_front();
    chk("rem", 32'(rem), 32'(y.rem));
    chk("busy", 32'(busy), 32'(y.rem != 0));
    chk("burst_cnt", 32'(cnt), 32'(y.cnt));
    chk("retrig", 32'(retrig), 32'(y.retrig));
    chk("burst_cnt_sat", 32'(cnt2), 32'(y.cnt2));
    chk("len1_rem", 32'(rem1), 32'd0);
    chk("len1_busy", 32'(busy1), 32'd0);
    chk("len1_retrig", 32'(retrig1), 32'd0);
    chk("len1_cnt", 32'(cnt1), 32'(y.cnt1));
  endtask

  // 20-cycle scenario after reset; a=1 at t0 and t1, en=0 at en_off, rst=0 at rst_off.
  task automatic scn(input string tag, input int t0, input int t1, input int en_off,
                     input int rst_off, input logic [31:0] eb, input logic [31:0] er,
                     input int ecnt);
    step(1'b0, 1'b0, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, -1);
    bh = '0; rh = '0;
    for (int i = 0; i < 20; i++) begin
      step((i == rst_off) ? 1'b0 : 1'b1, (i == en_off) ? 1'b0 : 1'b1,
           (i == t0 || i == t1 || i == en_off) ? 1'b1 : 1'b0, i);
    end
    chk({tag, "_b_pattern"}, bh & 32'hFFFFF, eb);
    chk({tag, "_retrig_pattern"}, rh & 32'hFFFFF, er);
    chk({tag, "_burst_cnt"}, 32'(cnt), 32'(ecnt));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; a = 1'b0;
    step(1'b0, 1'b1, 1'b1, -1);
    chk("reset_rem", 32'(rem), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_retrig", 32'(retrig), 32'd0);

    scn("single", 10, -1, -1, -1, 32'h01C00, 32'h00000, 1);
    scn("retrig", 10, 11, -1, -1, 32'h03C00, 32'h01000, 1);
    scn("b2b",    10, 13, -1, -1, 32'h0FC00, 32'h00000, 2);
    scn("engate", 10, -1, 11, -1, 32'h01C00, 32'h00000, 1);
    scn("rstmid", 10, -1, -1, 11, 32'h00400, 32'h00000, 0);

    step(1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, -1);
      for (int j = 0; j < RL; j++) step(1'b1, 1'b1, 1'b0, -1);
    end
    chk("sat_cnt_w2", 32'(cnt2), 32'd3);
    chk("sat_cnt_w8", 32'(cnt), 32'd6);

    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
